// File: rtl/mp4_types.sv
// Shared types for the mp4 core: opcodes, funct3 codes, ALU ops, FSM states, helpers.
// Latency: n/a (package only).
// Backpressure: n/a. Ports: none.
package mp4_types;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h6000_0000;
  localparam logic [31:0] HALT_INST_DEFAULT = 32'h0007_d463;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL   = 7'b1101111,
    OPC_JALR   = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
    OPC_STORE  = 7'b0100011, OPC_IMM   = 7'b0010011, OPC_REG   = 7'b0110011,
    OPC_FENCE  = 7'b0001111, OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {BR_EQ = 3'd0, BR_NE = 3'd1, BR_LT = 3'd4,
                            BR_GE = 3'd5, BR_LTU = 3'd6, BR_GEU = 3'd7} branch_f3_e;
  typedef enum logic [2:0] {LD_B = 3'd0, LD_H = 3'd1, LD_W = 3'd2,
                            LD_BU = 3'd4, LD_HU = 3'd5} load_f3_e;
  typedef enum logic [2:0] {ST_B = 3'd0, ST_H = 3'd1, ST_W = 3'd2} store_f3_e;
  typedef enum logic [2:0] {AR_ADD = 3'd0, AR_SLL = 3'd1, AR_SLT = 3'd2, AR_SLTU = 3'd3,
                            AR_XOR = 3'd4, AR_SR = 3'd5, AR_OR = 3'd6, AR_AND = 3'd7} arith_f3_e;
  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND} alu_op_e;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_COMMIT} state_e;

  // alt is instr[30], already qualified by the caller for where it is meaningful.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      AR_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      AR_SLL:  op = ALU_SLL;
      AR_SLT:  op = ALU_SLT;
      AR_SLTU: op = ALU_SLTU;
      AR_XOR:  op = ALU_XOR;
      AR_SR:   op = alt ? ALU_SRA : ALU_SRL;
      AR_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   r = a | b;
      default:  r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic t;
    case (f3)
      BR_EQ:   t = (a == b);
      BR_NE:   t = (a != b);
      BR_LT:   t = ($signed(a) < $signed(b));
      BR_GE:   t = ($signed(a) >= $signed(b));
      BR_LTU:  t = (a < b);
      BR_GEU:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] rdata, input logic [1:0] off);
    logic [31:0] s;
    logic [31:0] r;
    s = rdata >> {off, 3'b000};
    case (f3)
      LD_B:    r = {{24{s[7]}}, s[7:0]};
      LD_H:    r = {{16{s[15]}}, s[15:0]};
      LD_BU:   r = {24'b0, s[7:0]};
      LD_HU:   r = {16'b0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // Shifts are done at 4-bit width, so a misaligned half simply loses its upper lane.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      ST_B:    m = 4'b0001 << off;
      ST_H:    m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/mp4_regfile.sv
// 32x32 integer register file, x0 reads as zero, asynchronous clear.
// Latency: combinational reads, write lands on the rising edge.
// Backpressure: none. Ports: clk/rst, we/waddr/wdata, raddr1/2 -> rdata1/2.
module mp4_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != 5'd0) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];
endmodule

// File: rtl/mp4_ooo_core.sv
// Multi-cycle RV32I core: FETCH -> EXEC -> (MEM) -> COMMIT, one instruction in flight.
// Latency: 3 cycles ALU/branch/jump, 4 cycles load/store with single-cycle memory responses.
// Backpressure: requests held stable until the matching resp; ports: imem/dmem magic ports, RVFI-style commit_*.
module mp4_ooo_core
  import mp4_types::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_INST = HALT_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_mem_resp,
  input  logic [31:0] instr_mem_rdata,
  input  logic        data_mem_resp,
  input  logic [31:0] data_mem_rdata,
  output logic        instr_read,
  output logic [31:0] instr_mem_address,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_mbe,
  output logic [31:0] data_mem_address,
  output logic [31:0] data_mem_wdata,
  output logic        commit_valid,
  output logic [31:0] commit_inst,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_pc_next,
  output logic [4:0]  commit_rd_addr,
  output logic [31:0] commit_rd_wdata,
  output logic        commit_load_regfile,
  output logic        commit_halt
);
  state_e      state_q, state_d;
  logic        armed_q;  // low for the first cycle after reset so a stale resp is dropped
  logic [31:0] pc_q, pc_d, ir_q, ir_d, pc_next_q, pc_next_d, result_q, result_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  mbe_q, mbe_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_rdata, rs2_rdata, eff_addr;
  logic        writes_rd, is_load, is_store, in_mem, rf_we;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign rd     = ir_q[11:7];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign writes_rd = opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_IMM, OPC_REG};
  assign eff_addr  = rs1_rdata + (is_store ? imm_s : imm_i);
  assign in_mem    = (state_q == S_MEM);
  assign rf_we     = (state_q == S_COMMIT) && writes_rd && (rd != 5'd0);

  mp4_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (result_q),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_rdata),
    .rdata2 (rs2_rdata)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pc_next_d = pc_next_q;
    result_d  = result_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mbe_d     = mbe_q;
    case (state_q)
      S_FETCH: begin
        if (armed_q && instr_mem_resp) begin
          ir_d    = instr_mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_next_d = pc_q + 32'd4;
        result_d  = '0;
        addr_d    = eff_addr;
        mbe_d     = store_mask(funct3, eff_addr[1:0]);
        wdata_d   = is_store ? (rs2_rdata << {eff_addr[1:0], 3'b000}) : '0;
        case (opcode)
          OPC_LUI:   result_d = imm_u;
          OPC_AUIPC: result_d = pc_q + imm_u;
          OPC_JAL: begin
            result_d  = pc_q + 32'd4;
            pc_next_d = pc_q + imm_j;
          end
          OPC_JALR: begin
            result_d  = pc_q + 32'd4;
            pc_next_d = (rs1_rdata + imm_i) & ~32'd1;
          end
          OPC_BRANCH: if (branch_taken(funct3, rs1_rdata, rs2_rdata)) pc_next_d = pc_q + imm_b;
          // instr[30] selects SRAI only for the shift-right encoding; ADDI has no subtract form
          OPC_IMM:   result_d = alu(alu_decode(funct3, ir_q[30] && funct3 == AR_SR), rs1_rdata, imm_i);
          OPC_REG:   result_d = alu(alu_decode(funct3, ir_q[30]), rs1_rdata, rs2_rdata);
          default:   ;
        endcase
        state_d = (is_load || is_store) ? S_MEM : S_COMMIT;
      end
      S_MEM: begin
        if (data_mem_resp) begin
          if (is_load) result_d = load_extend(funct3, data_mem_rdata, addr_q[1:0]);
          state_d = S_COMMIT;
        end
      end
      default: begin
        pc_d    = pc_next_q;
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      armed_q   <= 1'b0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      pc_next_q <= '0;
      result_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mbe_q     <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pc_next_q <= pc_next_d;
      result_q  <= result_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mbe_q     <= mbe_d;
    end
  end

  assign instr_read        = armed_q && (state_q == S_FETCH);
  assign instr_mem_address = pc_q;
  assign data_read         = in_mem && is_load;
  assign data_write        = in_mem && is_store;
  assign data_mbe          = in_mem ? mbe_q : '0;
  assign data_mem_address  = in_mem ? {addr_q[31:2], 2'b00} : '0;
  assign data_mem_wdata    = in_mem ? wdata_q : '0;

  assign commit_valid        = (state_q == S_COMMIT);
  assign commit_inst         = commit_valid ? ir_q : '0;
  assign commit_pc           = commit_valid ? pc_q : '0;
  assign commit_pc_next      = commit_valid ? pc_next_q : '0;
  assign commit_rd_addr      = (commit_valid && writes_rd) ? rd : '0;
  assign commit_load_regfile = rf_we;
  assign commit_rd_wdata     = rf_we ? result_q : '0;
  assign commit_halt         = commit_valid && (ir_q == HALT_INST);
endmodule

// File: tb/tb_mp4_ooo_core.sv
// Bench for mp4_ooo_core: magic memories with random stalls, commit scoreboard, reset corners.
// Latency: n/a. Backpressure: responder inserts random wait states on both memory ports.
module tb_mp4_ooo_core;
  localparam logic [31:0] RST_PC = 32'h6000_0000;
  localparam logic [31:0] HALT   = 32'h0007_d463;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_mem_resp, data_mem_resp;
  logic [31:0] instr_mem_rdata, data_mem_rdata;
  logic        instr_read, data_read, data_write;
  logic [31:0] instr_mem_address, data_mem_address, data_mem_wdata;
  logic [3:0]  data_mbe;
  logic        commit_valid, commit_load_regfile, commit_halt;
  logic [31:0] commit_inst, commit_pc, commit_pc_next, commit_rd_wdata;
  logic [4:0]  commit_rd_addr;

  always #5 clk = ~clk;

  mp4_ooo_core dut (
    .clk(clk), .rst(rst),
    .instr_mem_resp(instr_mem_resp), .instr_mem_rdata(instr_mem_rdata),
    .data_mem_resp(data_mem_resp), .data_mem_rdata(data_mem_rdata),
    .instr_read(instr_read), .instr_mem_address(instr_mem_address),
    .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
    .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
    .commit_valid(commit_valid), .commit_inst(commit_inst), .commit_pc(commit_pc),
    .commit_pc_next(commit_pc_next), .commit_rd_addr(commit_rd_addr),
    .commit_rd_wdata(commit_rd_wdata), .commit_load_regfile(commit_load_regfile),
    .commit_halt(commit_halt)
  );

  typedef struct {
    logic [31:0] pc, inst, wdata, pc_next;
    logic [4:0]  rd;
    logic        ld, halt, st;
    logic [3:0]  mbe;
    logic [31:0] maddr, mwdata;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                              input logic [31:0] wdata, input logic [31:0] pc_next);
    vec_t r;
    r.pc = pc; r.inst = inst; r.rd = rd; r.wdata = wdata; r.pc_next = pc_next;
    r.ld = (rd != 5'd0); r.halt = (inst == HALT); r.st = 1'b0;
    r.mbe = 4'h0; r.maddr = '0; r.mwdata = '0;
    return r;
  endfunction
  function automatic vec_t mks(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] maddr,
                               input logic [3:0] mbe, input logic [31:0] mwdata);
    vec_t r;
    r = mk(pc, inst, 5'd0, 32'h0, pc + 32'd4);
    r.st = 1'b1; r.maddr = maddr; r.mbe = mbe; r.mwdata = mwdata;
    return r;
  endfunction

  logic [31:0] imem [logic [31:0]];
  logic [31:0] dmem [logic [31:0]];
  logic        mem_en = 1'b0;
  logic        force_iresp = 1'b0;
  logic [31:0] st_addr = '0, st_wdata = '0;
  logic [3:0]  st_mbe = '0;
  logic [31:0] poison;
  vec_t        tbl[$];
  vec_t        exp_q[$];

  // Magic memory: drives responses on the falling edge so they are seen at the next rising edge.
  initial begin
    logic [31:0] w;
    instr_mem_resp = 1'b0; instr_mem_rdata = '0; data_mem_resp = 1'b0; data_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        instr_mem_resp  = force_iresp;
        instr_mem_rdata = poison;
        data_mem_resp   = 1'b0;
      end else begin
        instr_mem_resp  = instr_read && ($urandom_range(0, 3) != 0);
        instr_mem_rdata = imem.exists(instr_mem_address) ? imem[instr_mem_address] : 32'h0000_0013;
        data_mem_resp   = (data_read || data_write) && ($urandom_range(0, 3) != 0);
        data_mem_rdata  = dmem.exists(data_mem_address) ? dmem[data_mem_address] : '0;
        if (data_write && data_mem_resp) begin
          w = dmem.exists(data_mem_address) ? dmem[data_mem_address] : '0;
          for (int b = 0; b < 4; b++)
            if (data_mbe[b]) w[8*b +: 8] = data_mem_wdata[8*b +: 8];
          dmem[data_mem_address] = w;
          st_addr = data_mem_address; st_mbe = data_mbe; st_wdata = data_mem_wdata;
        end
      end
    end
  end

  initial begin
    int commits;
    poison = enc_i(12'd99, 5'd0, 3'd0, 5'd31, 7'h13);  // ADDI x31,x0,99: must never retire
    tbl.push_back(mk(32'h6000_0000, enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 5'd1, 32'd5, 32'h6000_0004));
    tbl.push_back(mk(32'h6000_0004, enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 5'd2, 32'd10, 32'h6000_0008));
    tbl.push_back(mk(32'h6000_0008, enc_u(20'h11223, 5'd2, 7'h37), 5'd2, 32'h1122_3000, 32'h6000_000C));
    tbl.push_back(mk(32'h6000_000C, enc_i(12'h344, 5'd2, 3'd0, 5'd2, 7'h13), 5'd2, 32'h1122_3344, 32'h6000_0010));
    tbl.push_back(mk(32'h6000_0010, enc_b(13'd8, 5'd0, 5'd0, 3'd0), 5'd0, 32'h0, 32'h6000_0018));
    tbl.push_back(mks(32'h6000_0018, enc_s(12'd0, 5'd2, 5'd0, 3'd2), 32'h0, 4'b1111, 32'h1122_3344));
    tbl.push_back(mks(32'h6000_001C, enc_s(12'd3, 5'd1, 5'd0, 3'd0), 32'h0, 4'b1000, 32'h0500_0000));
    tbl.push_back(mk(32'h6000_0020, enc_u(20'h60000, 5'd3, 7'h37), 5'd3, 32'h6000_0000, 32'h6000_0024));
    tbl.push_back(mk(32'h6000_0024, enc_i(12'h100, 5'd3, 3'd0, 5'd3, 7'h13), 5'd3, 32'h6000_0100, 32'h6000_0028));
    tbl.push_back(mk(32'h6000_0028, enc_i(12'd1, 5'd3, 3'd0, 5'd1, 7'h67), 5'd1, 32'h6000_002C, 32'h6000_0100));
    tbl.push_back(mk(32'h6000_0100, enc_i(12'h103, 5'd0, 3'd0, 5'd4, 7'h03), 5'd4, 32'hFFFF_FF80, 32'h6000_0104));
    tbl.push_back(mk(32'h6000_0104, enc_i(12'h103, 5'd0, 3'd4, 5'd5, 7'h03), 5'd5, 32'h0000_0080, 32'h6000_0108));
    tbl.push_back(mk(32'h6000_0108, enc_i(12'h100, 5'd0, 3'd1, 5'd6, 7'h03), 5'd6, 32'h0000_7F01, 32'h6000_010C));
    tbl.push_back(mk(32'h6000_010C, enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd7), 5'd7, 32'h9FFF_FFD4, 32'h6000_0110));
    tbl.push_back(mk(32'h6000_0110, enc_i(12'h404, 5'd4, 3'd5, 5'd8, 7'h13), 5'd8, 32'hFFFF_FFF8, 32'h6000_0114));
    tbl.push_back(mk(32'h6000_0114, enc_r(7'h00, 5'd6, 5'd5, 3'd3, 5'd9), 5'd9, 32'h1, 32'h6000_0118));
    tbl.push_back(mk(32'h6000_0118, enc_b(13'd16, 5'd5, 5'd5, 3'd1), 5'd0, 32'h0, 32'h6000_011C));
    tbl.push_back(mk(32'h6000_011C, enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13), 5'd0, 32'h0, 32'h6000_0120));
    tbl.push_back(mk(32'h6000_0120, enc_i(12'd0, 5'd0, 3'd2, 5'd10, 7'h03), 5'd10, 32'h0522_3344, 32'h6000_0124));
    tbl.push_back(mk(32'h6000_0124, 32'h0000_0073, 5'd0, 32'h0, 32'h6000_0128));
    tbl.push_back(mk(32'h6000_0128, enc_u(20'h00001, 5'd11, 7'h17), 5'd11, 32'h6000_1128, 32'h6000_012C));
    tbl.push_back(mk(32'h6000_012C, enc_j(21'd8, 5'd12), 5'd12, 32'h6000_0130, 32'h6000_0134));
    tbl.push_back(mk(32'h6000_0134, HALT, 5'd0, 32'h0, 32'h6000_013C));

    foreach (tbl[i]) imem[tbl[i].pc] = tbl[i].inst;
    imem[32'h6000_0014] = poison;
    imem[32'h6000_0130] = poison;
    dmem[32'h0000_0000] = 32'h0;
    dmem[32'h0000_0100] = 32'h80FF_7F01;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_instr_read", instr_read, 1'b0);
    chk("rst_instr_addr", instr_mem_address, RST_PC);
    chk("rst_data_read", data_read, 1'b0);
    chk("rst_data_write", data_write, 1'b0);
    chk("rst_commit_valid", commit_valid, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("fetch_req", instr_read, 1'b1);
    chk("fetch_addr", instr_mem_address, RST_PC);

    // Asynchronous reset while a fetch is outstanding, with a response pending across release.
    #2;
    rst = 1'b1;
    force_iresp = 1'b1;
    #1;
    chk("async_rst_instr_read", instr_read, 1'b0);
    chk("async_rst_addr", instr_mem_address, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 force_iresp = 1'b0;
    commits = 0;
    repeat (4) begin
      @(negedge clk);
      if (commit_valid) commits++;
    end
    chk("stale_resp_ignored", commits, 0);
    chk("refetch_req", instr_read, 1'b1);
    chk("refetch_addr", instr_mem_address, RST_PC);

    // Program run: expected commits are queued as the memory is opened to the core.
    @(posedge clk);
    #1 mem_en = 1'b1;
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    for (int i = 0; i < tbl.size(); i++) begin
      int   cyc;
      vec_t e;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!commit_valid && cyc < 200);
      if (!commit_valid) begin
        chk($sformatf("commit_timeout[%0d]", i), commit_valid, 1'b1);
        break;
      end
      e = exp_q.pop_front();
      chk($sformatf("pc[%0d]", i), commit_pc, e.pc);
      chk($sformatf("inst[%0d]", i), commit_inst, e.inst);
      chk($sformatf("pc_next[%0d]", i), commit_pc_next, e.pc_next);
      chk($sformatf("rd_addr[%0d]", i), commit_rd_addr, e.rd);
      chk($sformatf("rd_wdata[%0d]", i), commit_rd_wdata, e.wdata);
      chk($sformatf("load_rf[%0d]", i), commit_load_regfile, e.ld);
      chk($sformatf("halt[%0d]", i), commit_halt, e.halt);
      if (e.st) begin
        chk($sformatf("st_addr[%0d]", i), st_addr, e.maddr);
        chk($sformatf("st_mbe[%0d]", i), st_mbe, e.mbe);
        chk($sformatf("st_wdata[%0d]", i), st_wdata, e.mwdata);
      end
    end
    @(negedge clk);
    chk("halt_one_cycle", commit_halt, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
